control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Hardwired Moore FSM sequencing the cpu datapath through fetch (T0-T2) and execute (T3-T6) for
//  register ALU instructions. Drives every datapath enable/out strobe and the ALU op_code, replacing
//  hand-driven control. Sits directly upstream of cpu; consumes IR contents and memory-ready.
// PARAMETERS
//  NREGS   16  general registers; reg_in/reg_out width
//  CNT_W   32  retired-instruction counter width
// PORTS
//  clk          in   1      rising-edge clock, sole clock
//  reset        in   1      synchronous, active-high
//  ir           in   32     IR contents: [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc
//  mem_ready    in   1      memory data valid on Mdatain this cycle
//  pc_out, mar_in, inc_pc, pc_in, mdr_read, mdr_in, mdr_out, ir_in, y_in  out 1  datapath strobes
//  zlo_in, zhi_in, zlo_out, zhi_out, lo_in, hi_in                          out 1  Z/HI/LO strobes
//  reg_in       out  NREGS  one-hot register load enable
//  reg_out      out  NREGS  one-hot register bus drive
//  op_code      out  5      ALU op; 5'b00000 outside T4
//  run          out  1      1 unless halted/in reset
//  illegal_op   out  1      one-cycle pulse on unsupported opcode
//  retired      out  CNT_W  count of completed instructions
// BEHAVIOUR
//  - Outputs are pure decode of registered state + ir; all outputs 0 (run 0, retired 0) while reset
//    high; reset wins over every other event, state -> RST, then T0 next cycle after release.
//  - T0: pc_out, mar_in, inc_pc, zlo_in.  T1: mdr_read, mdr_in, zlo_out, pc_in, inc_pc held; advance to
//    T2 only when mem_ready=1 at posedge; otherwise stay in T1W with mdr_read, mdr_in only (pc_in once).
//  - T2: mdr_out, ir_in.  T3: reg_out[Rb], y_in.
//  - T4: reg_out[Rc] (reg_out[Rb] for neg/not), op_code=ir[31:27], zlo_in; mul/div also zhi_in.
//  - T5: zlo_out, reg_in[Ra]; mul/div: zlo_out, lo_in.  T6 (mul/div only): zhi_out, hi_in.
//  - Supported: add 00011 sub 00100 and 00101 or 00110 shr 00111 shra 01000 shl 01001 ror 01010
//    rol 01011 mul 01111 div 10000 neg 10001 not 10010 nop 11010 halt 11011.
//  - Decode at T3 entry: nop -> T0 (retire); halt -> HALT (run=0, all strobes 0, stays until reset);
//    other unsupported -> illegal_op for the T3 cycle, no strobes, -> T0, not retired.
//  - retired increments on the last execute cycle (T5, T6 for mul/div, T3 for nop); wraps at 2^CNT_W.
//  - Never more than one reg_out/bus source asserted in any cycle; reg_in and reg_out never same cycle.
//  - Latency: ALU op 6 cycles, mul/div 7, plus one per cycle mem_ready low in T1.
// CONFIGURATION
//  CU_SINGLE_STEP_EN: adds input step (1 bit). After each retire/illegal, FSM enters WAIT; leaves to
//  T0 on cycle after step=1 sampled. step high during execute is ignored. Undefined: free-running,
//  last execute state -> T0 directly, no step port.
// STRUCTURE
//  - cpu_ctrl_pkg: opcode localparams, state encoding localparams, field bit positions.
//  - Sub-module reg_select_decoder: 4-bit field + gate -> NREGS one-hot; two instances (in, out).
// TESTING
//  1 reset 2 cycles, ir=0x5B320000 (rol r6,r6,r4), mem_ready=1 -> T3 reg_out[6]+y_in, T4 reg_out[4]
//    op_code=01011 zlo_in, T5 zlo_out reg_in[6]; retired=1 after 6 cycles.
//  2 ir=0x78188000 (mul r3,r1) -> T4 zlo_in+zhi_in op 01111, T5 lo_in, T6 hi_in, no reg_in; latency 7.
//  3 mem_ready low 3 cycles in T1 -> mdr_read high 4 cycles, pc_in exactly once, then T2.
//  4 ir=0xF8000000 -> illegal_op one pulse in T3, no reg_in, back to T0, retired unchanged.
//  5 ir=0xD8000000 (halt) -> run=0, all strobes 0 for 20 cycles; reset restores run=1 at T0.
//  6 reset asserted during T4 -> next cycle all outputs 0, op_code 0, retired 0; fetch restarts T0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the hardwired CPU control unit.
//   - opcode values of the supported register ALU instructions
//   - IR field bit positions
//   - FSM state encoding
//   - small opcode classification helpers
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int IR_OP_HI = 31;
    localparam int IR_OP_LO = 27;
    localparam int IR_RA_HI = 26;
    localparam int IR_RA_LO = 23;
    localparam int IR_RB_HI = 22;
    localparam int IR_RB_LO = 19;
    localparam int IR_RC_HI = 18;
    localparam int IR_RC_LO = 15;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T1W  = 4'd3,
        ST_T2   = 4'd4,
        ST_T3   = 4'd5,
        ST_T4   = 4'd6,
        ST_T5   = 4'd7,
        ST_T6   = 4'd8,
        ST_HALT = 4'd9,
        ST_WAIT = 4'd10
    } state_t;

    // Instructions that run the full T3..T5(/T6) register datapath sequence.
    function automatic logic is_alu_op(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
                          OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT};
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Single-operand ops take their second ALU input from Rb instead of Rc.
    function automatic logic is_unary(input logic [4:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// reg_select_decoder: turns a 4-bit register field into a one-hot enable.
//   sel    in  4      register number
//   en     in  1      gate; all outputs 0 when low
//   onehot out NREGS  one-hot select (bit sel set when en)
module reg_select_decoder #(
    parameter int NREGS = 16
) (
    input  logic [3:0]       sel,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            onehot[i] = en && (sel == 4'(i));
        end
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired Moore FSM sequencing the cpu datapath through
// fetch (T0..T2) and execute (T3..T6) for register ALU instructions.
// Build option: CU_SINGLE_STEP_EN adds the 'step' input; after every retire or
// illegal opcode the FSM parks in WAIT until step is sampled high.
// Ports:
//   clk, reset (sync, active-high), ir[31:0], mem_ready, [step]
//   datapath strobes: pc_out mar_in inc_pc pc_in mdr_read mdr_in mdr_out ir_in y_in
//   Z/HI/LO strobes:  zlo_in zhi_in zlo_out zhi_out lo_in hi_in
//   reg_in/reg_out (one-hot NREGS), op_code[4:0], run, illegal_op, retired[CNT_W-1:0]
//
// state | meaning
// RST   | in/just out of reset, all outputs 0
// T0    | PC -> MAR, PC+1 -> Z
// T1    | memory read started, Z -> PC
// T1W   | waiting for mem_ready, read held
// T2    | MDR -> IR
// T3    | decode; Rb -> Y (or nop retire / halt / illegal)
// T4    | ALU op on Y and Rc (Rb for neg/not) -> Z
// T5    | ZLO -> Ra, or ZLO -> LO for mul/div
// T6    | ZHI -> HI (mul/div only)
// HALT  | stopped until reset
// WAIT  | single-step park (CU_SINGLE_STEP_EN only)
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
`ifdef CU_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    output logic             pc_out,
    output logic             mar_in,
    output logic             inc_pc,
    output logic             pc_in,
    output logic             mdr_read,
    output logic             mdr_in,
    output logic             mdr_out,
    output logic             ir_in,
    output logic             y_in,
    output logic             zlo_in,
    output logic             zhi_in,
    output logic             zlo_out,
    output logic             zhi_out,
    output logic             lo_in,
    output logic             hi_in,
    output logic [NREGS-1:0] reg_in,
    output logic [NREGS-1:0] reg_out,
    output logic [4:0]       op_code,
    output logic             run,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       reg_in_en, reg_out_en;
    logic [3:0] reg_out_sel;
    state_t     after_retire;
    logic       ir_unused;

    assign op        = ir[IR_OP_HI:IR_OP_LO];
    assign ra        = ir[IR_RA_HI:IR_RA_LO];
    assign rb        = ir[IR_RB_HI:IR_RB_LO];
    assign rc        = ir[IR_RC_HI:IR_RC_LO];
    assign ir_unused = ^ir[IR_RC_LO-1:0];

`ifdef CU_SINGLE_STEP_EN
    assign after_retire = ST_WAIT;
`else
    assign after_retire = ST_T0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RST;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        retired_d   = retired_q;
        pc_out      = 1'b0;
        mar_in      = 1'b0;
        inc_pc      = 1'b0;
        pc_in       = 1'b0;
        mdr_read    = 1'b0;
        mdr_in      = 1'b0;
        mdr_out     = 1'b0;
        ir_in       = 1'b0;
        y_in        = 1'b0;
        zlo_in      = 1'b0;
        zhi_in      = 1'b0;
        zlo_out     = 1'b0;
        zhi_out     = 1'b0;
        lo_in       = 1'b0;
        hi_in       = 1'b0;
        op_code     = 5'b00000;
        illegal_op  = 1'b0;
        run         = 1'b1;
        reg_in_en   = 1'b0;
        reg_out_en  = 1'b0;
        reg_out_sel = rb;

        case (state_q)
            ST_RST: begin
                run     = 1'b0;
                state_d = ST_T0;
            end
            ST_T0: begin
                pc_out  = 1'b1;
                mar_in  = 1'b1;
                inc_pc  = 1'b1;
                zlo_in  = 1'b1;
                state_d = ST_T1;
            end
            ST_T1: begin
                // PC is reloaded only here so a stalled read never re-increments it.
                mdr_read = 1'b1;
                mdr_in   = 1'b1;
                zlo_out  = 1'b1;
                pc_in    = 1'b1;
                inc_pc   = 1'b1;
                state_d  = mem_ready ? ST_T2 : ST_T1W;
            end
            ST_T1W: begin
                mdr_read = 1'b1;
                mdr_in   = 1'b1;
                if (mem_ready) state_d = ST_T2;
            end
            ST_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
                state_d = ST_T3;
            end
            ST_T3: begin
                if (op == OP_NOP) begin
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = after_retire;
                end else if (op == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (!is_alu_op(op)) begin
                    illegal_op = 1'b1;
                    state_d    = after_retire;
                end else begin
                    reg_out_en = 1'b1;
                    y_in       = 1'b1;
                    state_d    = ST_T4;
                end
            end
            ST_T4: begin
                reg_out_en  = 1'b1;
                reg_out_sel = is_unary(op) ? rb : rc;
                op_code     = op;
                zlo_in      = 1'b1;
                zhi_in      = is_muldiv(op);
                state_d     = ST_T5;
            end
            ST_T5: begin
                zlo_out = 1'b1;
                if (is_muldiv(op)) begin
                    lo_in   = 1'b1;
                    state_d = ST_T6;
                end else begin
                    reg_in_en = 1'b1;
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = after_retire;
                end
            end
            ST_T6: begin
                zhi_out   = 1'b1;
                hi_in     = 1'b1;
                retired_d = retired_q + CNT_W'(1);
                state_d   = after_retire;
            end
            ST_HALT: begin
                run = 1'b0;
            end
`ifdef CU_SINGLE_STEP_EN
            ST_WAIT: begin
                if (step) state_d = ST_T0;
            end
`endif
            default: begin
                run     = 1'b0;
                state_d = ST_RST;
            end
        endcase
    end

    assign retired = retired_q;

    reg_select_decoder #(.NREGS(NREGS)) u_reg_in_dec (
        .sel    (ra),
        .en     (reg_in_en),
        .onehot (reg_in)
    );

    reg_select_decoder #(.NREGS(NREGS)) u_reg_out_dec (
        .sel    (reg_out_sel),
        .en     (reg_out_en),
        .onehot (reg_out)
    );

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed + randomized bench for control_unit (default build).
// Each instruction is expanded into the cycle-by-cycle list of expected output
// words from the instruction-level rules, then played against the DUT.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir;
    logic        mem_ready;
    logic        pc_out, mar_in, inc_pc, pc_in, mdr_read, mdr_in, mdr_out, ir_in, y_in;
    logic        zlo_in, zhi_in, zlo_out, zhi_out, lo_in, hi_in;
    logic [15:0] reg_in, reg_out;
    logic [4:0]  op_code;
    logic        run, illegal_op;
    logic [31:0] retired;

    always #5 clk = ~clk;

    control_unit #(.NREGS(16), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .ir(ir), .mem_ready(mem_ready),
        .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .pc_in(pc_in),
        .mdr_read(mdr_read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
        .y_in(y_in), .zlo_in(zlo_in), .zhi_in(zhi_in), .zlo_out(zlo_out),
        .zhi_out(zhi_out), .lo_in(lo_in), .hi_in(hi_in),
        .reg_in(reg_in), .reg_out(reg_out), .op_code(op_code),
        .run(run), .illegal_op(illegal_op), .retired(retired)
    );

    typedef struct packed {
        logic pc_out, mar_in, inc_pc, pc_in, mdr_read, mdr_in, mdr_out, ir_in, y_in;
        logic zlo_in, zhi_in, zlo_out, zhi_out, lo_in, hi_in, illegal_op, run;
        logic [15:0] reg_in;
        logic [15:0] reg_out;
        logic [4:0]  op_code;
    } obs_t;

    obs_t got;
    assign got = {pc_out, mar_in, inc_pc, pc_in, mdr_read, mdr_in, mdr_out, ir_in, y_in,
                  zlo_in, zhi_in, zlo_out, zhi_out, lo_in, hi_in, illegal_op, run,
                  reg_in, reg_out, op_code};

    obs_t        exp_q[$];
    logic        exp_retire;
    logic [31:0] model_retired;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
        end
    endtask

    function automatic obs_t idle_word();
        obs_t o;
        o     = '0;
        o.run = 1'b1;
        return o;
    endfunction

    // Expected per-cycle outputs for one instruction, starting at T0.
    task automatic build_seq(input logic [31:0] instr, input int stall);
        obs_t       o;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        logic       alu, muldiv;
        op = instr[31:27];
        ra = instr[26:23];
        rb = instr[22:19];
        rc = instr[18:15];
        alu = op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                         5'b01001, 5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001, 5'b10010};
        muldiv = (op == 5'b01111) || (op == 5'b10000);
        exp_q.delete();
        o = idle_word(); o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.zlo_in = 1;
        exp_q.push_back(o);
        o = idle_word(); o.mdr_read = 1; o.mdr_in = 1; o.zlo_out = 1; o.pc_in = 1; o.inc_pc = 1;
        exp_q.push_back(o);
        for (int s = 0; s < stall; s++) begin
            o = idle_word(); o.mdr_read = 1; o.mdr_in = 1;
            exp_q.push_back(o);
        end
        o = idle_word(); o.mdr_out = 1; o.ir_in = 1;
        exp_q.push_back(o);
        exp_retire = 1'b0;
        if (op == 5'b11010) begin
            exp_q.push_back(idle_word());
            exp_retire = 1'b1;
        end else if (op == 5'b11011) begin
            exp_q.push_back(idle_word());
        end else if (!alu) begin
            o = idle_word(); o.illegal_op = 1;
            exp_q.push_back(o);
        end else begin
            o = idle_word(); o.reg_out = 16'h1 << rb; o.y_in = 1;
            exp_q.push_back(o);
            o = idle_word(); o.reg_out = 16'h1 << ((op == 5'b10001 || op == 5'b10010) ? rb : rc);
            o.op_code = op; o.zlo_in = 1; o.zhi_in = muldiv;
            exp_q.push_back(o);
            o = idle_word(); o.zlo_out = 1;
            if (muldiv) o.lo_in = 1; else o.reg_in = 16'h1 << ra;
            exp_q.push_back(o);
            if (muldiv) begin
                o = idle_word(); o.zhi_out = 1; o.hi_in = 1;
                exp_q.push_back(o);
            end
            exp_retire = 1'b1;
        end
    endtask

    // Plays the first n expected cycles; entered and left just after a posedge.
    task automatic play(input string name, input int n, input int stall);
        for (int i = 0; i < n; i++) begin
            if (i >= 1 && i < 1 + stall) mem_ready = 1'b0;
            else if (i == 1 + stall)     mem_ready = 1'b1;
            else                         mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk($sformatf("%s c%0d outs", name, i), 64'(got), 64'(exp_q[i]));
            chk($sformatf("%s c%0d retired", name, i), 64'(retired), 64'(model_retired));
            @(posedge clk); #1;
        end
    endtask

    task automatic run_instr(input string name, input logic [31:0] instr, input int stall);
        ir = instr;
        build_seq(instr, stall);
        play(name, exp_q.size(), stall);
        if (exp_retire) model_retired = model_retired + 1;
    endtask

    // Two reset cycles, one RST cycle after release; returns with the DUT in T0.
    task automatic do_reset(input string name);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk({name, " rst outs"}, 64'(got), 64'(0));
        chk({name, " rst retired"}, 64'(retired), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        model_retired = 0;
        @(negedge clk);
        chk({name, " rst release outs"}, 64'(got), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [4:0] op;
        int         stall;
        ir            = 32'h0;
        mem_ready     = 1'b1;
        model_retired = 0;
        exp_retire    = 1'b0;

        do_reset("init");

        run_instr("rol", 32'h5B320000, 0);
        run_instr("mul", 32'h78188000, 0);
        run_instr("stall3", 32'h5B320000, 3);
        run_instr("illegal", 32'hF8000000, 0);
        run_instr("nop", 32'hD0000000, 1);
        run_instr("neg", 32'h88A40000, 2);

        // reset in the middle of T4 (T0,T1,T2,T3 played, DUT now in T4)
        ir = 32'h5B320000;
        build_seq(ir, 0);
        play("pre_rst", 4, 0);
        do_reset("midT4");
        run_instr("after_rst", 32'h0B320000, 0);

        for (int k = 0; k < 40; k++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11011) op = 5'b10000;
            stall = $urandom_range(0, 3);
            run_instr($sformatf("rnd%0d", k), {op, 27'($urandom)}, stall);
        end

        run_instr("halt", 32'hD8000000, 0);
        for (int c = 0; c < 20; c++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk($sformatf("halted c%0d", c), 64'(got), 64'(0));
            @(posedge clk); #1;
        end
        do_reset("halt");
        run_instr("post_halt", 32'h1AB40000, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
